window_sequencer: RTL

Top-level sequencer for the autotune window pipeline. It converts the raw ADC sample stream into addressed window writes and detects window boundaries. It starts pitch detection (YIN) on each completed window, then hands the validated tau to the PSOLA/BRAM datapath and waits for that datapath to finish. Windows that complete while the previous one is still in flight are dropped and counted, so the datapath is never re-triggered mid-operation.

---
 rtl/window_sequencer_if.sv | 35 +++
 rtl/window_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/window_sequencer_if.sv
// Bundles the sample, YIN and datapath signals of the window sequencer.
// Pure wiring, no latency.
// No backpressure: every signal is a strobe or a level.
interface window_sequencer_if #(
    parameter int ADDR_W = 11
);
    logic              audio_valid_in;
    logic [31:0]       audio_in;
    logic [31:0]       sample_out;
    logic [ADDR_W-1:0] addr_out;
    logic              sample_valid_out;
    logic              yin_start_out;
    logic              tau_valid_in;
    logic [11:0]       tau_in;
    logic              tau_valid_out;
    logic [11:0]       tau_out;
    logic              proc_done_in;
    logic              busy_out;
    logic [15:0]       drop_count_out;
    logic [15:0]       timeout_count_out;

    // Environment side: ADC, YIN engine and datapath.
    modport master (
        output audio_valid_in, audio_in, tau_valid_in, tau_in, proc_done_in,
        input  sample_out, addr_out, sample_valid_out, yin_start_out,
               tau_valid_out, tau_out, busy_out, drop_count_out, timeout_count_out
    );

    // Sequencer side.
    modport slave (
        input  audio_valid_in, audio_in, tau_valid_in, tau_in, proc_done_in,
        output sample_out, addr_out, sample_valid_out, yin_start_out,
               tau_valid_out, tau_out, busy_out, drop_count_out, timeout_count_out
    );
endinterface

// File: rtl/window_sequencer.sv
// Turns the ADC stream into addressed window writes, starts YIN per window, forwards tau, waits for datapath.
// Latency: sample write 1 cycle, yin_start 2 cycles after final sample, tau_out 1 cycle after tau_valid_in.
// No backpressure: samples are never stalled; windows arriving while busy are dropped and counted.
module window_sequencer #(
    parameter int WINDOW_SIZE = 2048,
    parameter int TAU_MAX     = 1024,
    parameter int TAU_DEFAULT = 200,
    parameter int YIN_TIMEOUT = 65535
) (
    input logic              clk_in,
    input logic              rst_in,
    window_sequencer_if.slave bus
);
    localparam int ADDR_W = $clog2(WINDOW_SIZE);
    localparam int TO_W   = (YIN_TIMEOUT > 1) ? $clog2(YIN_TIMEOUT) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WINDOW_SIZE - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(YIN_TIMEOUT - 1);
    localparam logic [11:0]       TAU_MAX_W = 12'(TAU_MAX);
    localparam logic [11:0]       TAU_DEF_W = 12'(TAU_DEFAULT);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_YIN = 2'd1,
        ST_PROCESS  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_nxt;

    logic [ADDR_W-1:0] wr_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       sample_q;
    logic              sample_vld_q;

    logic [TO_W-1:0]   to_cnt_q;
    logic [11:0]       last_tau_q;
    logic [11:0]       tau_q;
    logic              tau_vld_q;
    logic              yin_start_q;
    logic              busy_q;
    logic [15:0]       drop_cnt_q;
    logic [15:0]       timeout_cnt_q;

    logic              boundary;
    logic              to_expired;
    logic              tau_ok;
    logic              yin_start_nxt;
    logic              tau_take;
    logic              timeout_evt;
    logic              drop_evt;

    // A boundary is the write of the last slot, seen while it is on the output.
    assign boundary   = sample_vld_q && (addr_q == LAST_ADDR);
    assign to_expired = (to_cnt_q == TO_LAST);
    assign tau_ok     = (bus.tau_in != 12'd0) && (bus.tau_in <= TAU_MAX_W);

    // Sample path: register every sample with its slot address, wrap the write counter.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_cnt_q     <= '0;
            addr_q       <= '0;
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
        end else begin
            sample_vld_q <= bus.audio_valid_in;
            if (bus.audio_valid_in) begin
                sample_q <= bus.audio_in;
                addr_q   <= wr_cnt_q;
                wr_cnt_q <= wr_cnt_q + ADDR_W'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state and events; completion (done/timeout) is resolved before a coincident boundary.
    always_comb begin
        state_nxt     = state_q;
        yin_start_nxt = 1'b0;
        tau_take      = 1'b0;
        timeout_evt   = 1'b0;
        drop_evt      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (boundary) begin
                    state_nxt     = ST_WAIT_YIN;
                    yin_start_nxt = 1'b1;
                end
            end
            ST_WAIT_YIN: begin
                if (bus.tau_valid_in) begin
                    tau_take  = 1'b1;
                    state_nxt = ST_PROCESS;
                    drop_evt  = boundary;
                end else if (to_expired) begin
                    timeout_evt = 1'b1;
                    if (boundary) begin
                        state_nxt     = ST_WAIT_YIN;
                        yin_start_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    drop_evt = boundary;
                end
            end
            ST_PROCESS: begin
                if (bus.proc_done_in) begin
                    if (boundary) begin
                        state_nxt     = ST_WAIT_YIN;
                        yin_start_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    drop_evt = boundary;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // YIN wait timer: restarts with every accepted window, runs only while waiting.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            to_cnt_q <= '0;
        end else if (yin_start_nxt) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_WAIT_YIN && !to_expired) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    // Tau hand-off: invalid estimates fall back to the last voiced tau.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tau_q      <= TAU_DEF_W;
            last_tau_q <= TAU_DEF_W;
            tau_vld_q  <= 1'b0;
        end else begin
            tau_vld_q <= tau_take;
            if (tau_take) begin
                if (tau_ok) begin
                    tau_q      <= bus.tau_in;
                    last_tau_q <= bus.tau_in;
                end else begin
                    tau_q <= last_tau_q;
                end
            end
        end
    end

    // Registered status: start pulse, busy level and saturating event counters.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            yin_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            drop_cnt_q    <= '0;
            timeout_cnt_q <= '0;
        end else begin
            yin_start_q <= yin_start_nxt;
            busy_q      <= (state_nxt != ST_IDLE);
            if (drop_evt && drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (timeout_evt && timeout_cnt_q != 16'hFFFF) begin
                timeout_cnt_q <= timeout_cnt_q + 16'd1;
            end
        end
    end

    assign bus.sample_out        = sample_q;
    assign bus.addr_out          = addr_q;
    assign bus.sample_valid_out  = sample_vld_q;
    assign bus.yin_start_out     = yin_start_q;
    assign bus.tau_valid_out     = tau_vld_q;
    assign bus.tau_out           = tau_q;
    assign bus.busy_out          = busy_q;
    assign bus.drop_count_out    = drop_cnt_q;
    assign bus.timeout_count_out = timeout_cnt_q;
endmodule
